// File: rtl/attention_z_engine.sv
// attention_z_engine
// Final stage of the self-attention pipeline. Once the Q/K/V and score
// passes are complete, this block reads the score matrix S (R x R) from
// result SRAM and the value matrix V (R x W) from scratchpad SRAM. It then
// writes Z = S * V (R x W) into result SRAM, directly after S.
//
// Memory layout (RW = R*W, RR = R*R, addresses wrap mod 2^ADDR_W):
//   S at 3*RW in result SRAM, V at RW in scratchpad, Z at 3*RW + RR.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   start                      one-cycle request, sampled only when idle
//   seq_len, head_dim          R and W, latched together with start
//   busy                       high in every non-idle state
//   done                       one-cycle pulse after the last Z write
//   result_read_address/data   S fetch; data returns one cycle later
//   scratchpad_read_address/data  V fetch; data returns one cycle later
//   result_write_enable/address/data  Z write port
module attention_z_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       seq_len,
    input  logic [15:0]       head_dim,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] result_read_address,
    input  logic [DATA_W-1:0] result_read_data,
    output logic [ADDR_W-1:0] scratchpad_read_address,
    input  logic [DATA_W-1:0] scratchpad_read_data,
    output logic              result_write_enable,
    output logic [ADDR_W-1:0] result_write_address,
    output logic [DATA_W-1:0] result_write_data
);

    typedef enum logic [1:0] {IDLE, SETUP, MAC, DONE} state_t;

    state_t            state;
    logic [15:0]       r_len;
    logic [15:0]       w_len;
    logic [15:0]       cnt_c;
    logic [15:0]       cnt_i;
    logic [15:0]       cnt_j;
    logic [ADDR_W-1:0] v_base;
    logic [ADDR_W-1:0] s_row;
    logic [ADDR_W-1:0] v_col;
    logic [ADDR_W-1:0] z_addr;
    logic [DATA_W-1:0] acc;

    logic [ADDR_W-1:0] rw_c;
    logic [ADDR_W-1:0] rr_c;
    logic [ADDR_W-1:0] s_base_c;
    logic [ADDR_W-1:0] z_base_c;
    logic [ADDR_W-1:0] r_step;
    logic [ADDR_W-1:0] w_step;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] acc_base;
    logic              last_read;
    logic              last_elem;

    // Base addresses are derived from the latched R and W while in SETUP.
    // They are consumed on the SETUP->MAC edge, so that the very first MAC
    // cycle already presents valid read addresses.
    assign rw_c     = ADDR_W'(r_len * w_len);
    assign rr_c     = ADDR_W'(r_len * r_len);
    assign s_base_c = (rw_c << 1) + rw_c;
    assign z_base_c = s_base_c + rr_c;
    assign r_step   = ADDR_W'(r_len);
    assign w_step   = ADDR_W'(w_len);

    // SRAM data arriving this cycle belongs to the address pair driven in
    // the previous cycle. The c==1 term starts a fresh sum, so the previous
    // element's accumulator is never mixed in.
    assign prod      = result_read_data * scratchpad_read_data;
    assign acc_base  = (cnt_c == 16'd1) ? '0 : acc;
    assign last_read = (cnt_c == r_len - 16'd1);
    assign last_elem = (cnt_i == r_len - 16'd1) && (cnt_j == w_len - 16'd1);

    // The final product is folded in combinationally, so the write happens
    // in the same cycle as the last operand pair returns.
    assign result_write_data = result_write_enable ? (acc_base + prod) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                   <= IDLE;
            r_len                   <= '0;
            w_len                   <= '0;
            cnt_c                   <= '0;
            cnt_i                   <= '0;
            cnt_j                   <= '0;
            v_base                  <= '0;
            s_row                   <= '0;
            v_col                   <= '0;
            z_addr                  <= '0;
            acc                     <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            result_read_address     <= '0;
            scratchpad_read_address <= '0;
            result_write_enable     <= 1'b0;
            result_write_address    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r_len <= seq_len;
                        w_len <= head_dim;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end

                SETUP: begin
                    cnt_c  <= '0;
                    cnt_i  <= '0;
                    cnt_j  <= '0;
                    v_base <= rw_c;
                    s_row  <= s_base_c;
                    v_col  <= rw_c;
                    z_addr <= z_base_c;
                    if (r_len == 16'd0 || w_len == 16'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        result_read_address     <= s_base_c;
                        scratchpad_read_address <= rw_c;
                        state                   <= MAC;
                    end
                end

                MAC: begin
                    if (cnt_c != 16'd0) begin
                        acc <= acc_base + prod;
                    end
                    if (cnt_c != r_len) begin
                        // Read phase. S walks along row i; V walks down column j.
                        cnt_c <= cnt_c + 16'd1;
                        if (last_read) begin
                            result_read_address     <= '0;
                            scratchpad_read_address <= '0;
                            result_write_enable     <= 1'b1;
                            result_write_address    <= z_addr;
                        end else begin
                            result_read_address     <= result_read_address + 1'b1;
                            scratchpad_read_address <= scratchpad_read_address + w_step;
                        end
                    end else begin
                        // Write cycle. Z is row-major with j fastest, so its
                        // address is simply sequential.
                        result_write_enable <= 1'b0;
                        z_addr              <= z_addr + 1'b1;
                        cnt_c               <= '0;
                        if (last_elem) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (cnt_j == w_len - 16'd1) begin
                            cnt_j                   <= '0;
                            cnt_i                   <= cnt_i + 16'd1;
                            s_row                   <= s_row + r_step;
                            v_col                   <= v_base;
                            result_read_address     <= s_row + r_step;
                            scratchpad_read_address <= v_base;
                        end else begin
                            cnt_j                   <= cnt_j + 16'd1;
                            v_col                   <= v_col + 1'b1;
                            result_read_address     <= s_row;
                            scratchpad_read_address <= v_col + 1'b1;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    cnt_c <= '0;
                    cnt_i <= '0;
                    cnt_j <= '0;
                    acc   <= '0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_attention_z_engine.sv
// tb_attention_z_engine
// Directed and randomized bench for attention_z_engine. Both SRAMs are
// modelled as arrays with one-cycle read latency. For every job, the
// expected Z values, write cycles and done cycle are computed up front
// from the matrix contents with plain loops. Each cycle's outputs are then
// compared against those expectations.
module tb_attention_z_engine;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       seq_len = '0;
    logic [15:0]       head_dim = '0;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] result_read_address;
    logic [DATA_W-1:0] result_read_data;
    logic [ADDR_W-1:0] scratchpad_read_address;
    logic [DATA_W-1:0] scratchpad_read_data;
    logic              result_write_enable;
    logic [ADDR_W-1:0] result_write_address;
    logic [DATA_W-1:0] result_write_data;

    logic [31:0] res_mem [0:65535];
    logic [31:0] sp_mem  [0:65535];

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [15:0] last_wa = '0;

    always #5 clk = ~clk;

    attention_z_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .seq_len                 (seq_len),
        .head_dim                (head_dim),
        .busy                    (busy),
        .done                    (done),
        .result_read_address     (result_read_address),
        .result_read_data        (result_read_data),
        .scratchpad_read_address (scratchpad_read_address),
        .scratchpad_read_data    (scratchpad_read_data),
        .result_write_enable     (result_write_enable),
        .result_write_address    (result_write_address),
        .result_write_data       (result_write_data)
    );

    // SRAM models: registered read data and a synchronous write on the result port.
    always @(posedge clk) begin
        result_read_data     <= res_mem[result_read_address];
        scratchpad_read_data <= sp_mem[scratchpad_read_address];
        if (result_write_enable === 1'b1) begin
            res_mem[result_write_address] = result_write_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " we"}, 32'(result_write_enable), 32'd0);
        checkOutput({tag, " wdata"}, result_write_data, 32'd0);
        checkOutput({tag, " waddr"}, 32'(result_write_address), 32'd0);
        checkOutput({tag, " raddr_s"}, 32'(result_read_address), 32'd0);
        checkOutput({tag, " raddr_v"}, 32'(scratchpad_read_address), 32'd0);
    endtask

    // Runs one job of size r x w and checks it cycle by cycle. Cycle 0 is
    // the cycle in which start is high. glitch_cyc > 0 raises start again
    // during that cycle, with R=1. reset_cyc > 0 pulls reset_n low in the
    // middle of that cycle; from then on, every output must stay at zero.
    task automatic applyStimulus(input int r, input int w, input int glitch_cyc, input int reset_cyc);
        int          rw;
        int          dc;
        int          s_base;
        int          v_base;
        int          z_base;
        int          e;
        int          rel;
        bit          aborted;
        bit          exp_we;
        bit          exp_busy;
        logic [31:0] sum;
        logic [31:0] z_exp [$];
        string       tag;

        rw     = r * w;
        s_base = 3 * rw;
        v_base = rw;
        z_base = 3 * rw + r * r;
        dc     = rw * (r + 1) + 2;
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < w; j++) begin
                sum = 32'd0;
                for (int k = 0; k < r; k++) begin
                    sum = sum + res_mem[16'(s_base + i * r + k)] * sp_mem[16'(v_base + k * w + j)];
                end
                z_exp.push_back(sum);
            end
        end

        aborted = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        seq_len  = 16'(r);
        head_dim = 16'(w);
        for (int t = 1; t <= dc + 2; t++) begin
            @(negedge clk);
            tag      = $sformatf("R%0dW%0d c%0d", r, w, t);
            exp_we   = 1'b0;
            e        = 0;
            rel      = t - (r + 2);
            if (!aborted && rw > 0 && rel >= 0 && (rel % (r + 1)) == 0 && (rel / (r + 1)) < rw) begin
                exp_we = 1'b1;
                e      = rel / (r + 1);
            end
            exp_busy = !aborted && t <= dc;

            checkOutput({tag, " busy"}, 32'(busy), 32'(exp_busy));
            checkOutput({tag, " done"}, 32'(done), 32'(!aborted && t == dc));
            checkOutput({tag, " we"}, 32'(result_write_enable), 32'(exp_we));
            if (exp_we) begin
                last_wa = 16'(z_base + e);
                checkOutput({tag, " waddr"}, 32'(result_write_address), 32'(last_wa));
                checkOutput({tag, " wdata"}, result_write_data, z_exp[e]);
            end else begin
                checkOutput({tag, " waddr hold"}, 32'(result_write_address), 32'(last_wa));
                checkOutput({tag, " wdata idle"}, result_write_data, 32'd0);
            end
            if (exp_we || !exp_busy || t == 1 || t == dc) begin
                checkOutput({tag, " raddr_s"}, 32'(result_read_address), 32'd0);
                checkOutput({tag, " raddr_v"}, 32'(scratchpad_read_address), 32'd0);
            end

            // Inputs move only after the cycle has been sampled.
            if (t == 1) begin
                start    = 1'b0;
                seq_len  = 16'($urandom);
                head_dim = 16'($urandom);
            end
            if (t == glitch_cyc - 1) begin
                start   = 1'b1;
                seq_len = 16'd1;
            end
            if (t == glitch_cyc) begin
                start = 1'b0;
            end
            if (t == reset_cyc) begin
                reset_n = 1'b0;
                #1;
                aborted = 1'b1;
                last_wa = '0;
                checkIdleOutputs({tag, " async reset"});
            end
        end
        if (aborted) begin
            @(negedge clk);
            reset_n = 1'b1;
        end
    endtask

    task automatic loadScenario1();
        res_mem[12] = 32'd1; res_mem[13] = 32'd2; res_mem[14] = 32'd3; res_mem[15] = 32'd4;
        sp_mem[4] = 32'd5; sp_mem[5] = 32'd6; sp_mem[6] = 32'd7; sp_mem[7] = 32'd8;
        for (int a = 16; a < 20; a++) res_mem[a] = 32'd0;
    endtask

    task automatic checkScenario1Memory(input string tag);
        checkOutput({tag, " z16"}, res_mem[16], 32'd19);
        checkOutput({tag, " z17"}, res_mem[17], 32'd22);
        checkOutput({tag, " z18"}, res_mem[18], 32'd43);
        checkOutput({tag, " z19"}, res_mem[19], 32'd50);
    endtask

    initial begin
        int r;
        int w;

        for (int a = 0; a < 65536; a++) begin
            res_mem[a] = 32'd0;
            sp_mem[a]  = 32'd0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        reset_n = 1'b1;
        @(negedge clk);
        checkIdleOutputs("post-reset idle");

        // Scenario 1: 2x2 by 2x2
        loadScenario1();
        applyStimulus(2, 2, 0, 0);
        checkScenario1Memory("s1");

        // Scenario 2: identity S, 3x1 V
        for (int a = 9; a < 18; a++) res_mem[a] = 32'd0;
        res_mem[9] = 32'd1; res_mem[13] = 32'd1; res_mem[17] = 32'd1;
        sp_mem[3] = 32'd10; sp_mem[4] = 32'd20; sp_mem[5] = 32'd30;
        applyStimulus(3, 1, 0, 0);
        checkOutput("s2 z18", res_mem[18], 32'd10);
        checkOutput("s2 z19", res_mem[19], 32'd20);
        checkOutput("s2 z20", res_mem[20], 32'd30);

        // Scenario 3: truncated product
        res_mem[3] = 32'hFFFF_FFFF;
        sp_mem[1]  = 32'd2;
        res_mem[4] = 32'd0;
        applyStimulus(1, 1, 0, 0);
        checkOutput("s3 z4", res_mem[4], 32'hFFFF_FFFE);

        // Scenario 4: empty dimensions
        applyStimulus(0, 5, 0, 0);
        applyStimulus(3, 0, 0, 0);

        // Scenario 5: start pulse mid-run is ignored
        loadScenario1();
        applyStimulus(2, 2, 5, 0);
        checkScenario1Memory("s5");

        // Scenario 6: reset mid-run, then a clean rerun
        loadScenario1();
        applyStimulus(2, 2, 0, 8);
        checkOutput("s6 z18 untouched", res_mem[18], 32'd0);
        checkOutput("s6 z19 untouched", res_mem[19], 32'd0);
        applyStimulus(2, 2, 0, 0);
        checkScenario1Memory("s6 rerun");

        // Randomized jobs with full-range data
        for (int n = 0; n < 8; n++) begin
            r = int'($urandom_range(1, 5));
            w = int'($urandom_range(1, 5));
            for (int a = 0; a < r * r; a++) res_mem[3 * r * w + a] = $urandom;
            for (int a = 0; a < r * w; a++) sp_mem[r * w + a] = $urandom;
            applyStimulus(r, w, (n == 3) ? 4 : 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
